instr_encoder_loader: RTL and testbench
=======================================

# instr_encoder_loader

Instruction encoder and program loader for the custom processor. It accepts decoded instruction fields over a valid/ready stream and packs each one into a 32-bit instruction word. The words are written in order into instruction memory, starting at address 0. It is the inverse of the processor's opcode decode stage and runs before the core leaves reset, for example fed by the unlock-sequence host interface.

## Interface

Parameters:
- ADDR_WIDTH, 12, instruction-memory word-address width; capacity 2^ADDR_WIDTH words

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse that arms a new load
- in_valid  in  1  field bundle valid
- in_ready  out  1  block accepts a bundle this cycle
- kind  in  3  0 R-type, 1 addi, 2 lw, 3 sw, 4 setx, 5 jal, 6–7 illegal
- in_last  in  1  bundle is the final instruction of the program
- rd, rs, rt  in  5 each  register fields
- shamt  in  5  shift amount (R-type)
- aluop  in  5  ALU op (R-type)
- imm  in  17  immediate (addi/lw/sw)
- target  in  27  target (jal/setx)
- imem_we  out  1  instruction-memory write strobe
- imem_addr  out  ADDR_WIDTH  write address
- imem_data  out  32  encoded instruction
- busy  out  1  high in LOAD
- done  out  1  high in DONE
- error  out  1  high in ERR
- count  out  ADDR_WIDTH+1  words written in current load

## Operation

Encoding (opcode in [31:27]):
- R-type: {00000, rd, rs, rt, shamt, aluop, 2'b00}
- addi: {00101, rd, rs, imm}
- lw: {01000, rd, rs, imm}
- sw: {00111, rd, rs, imm}; the rd field carries the store-data register
- setx: {10101, target}
- jal: {00011, target}

States:
- IDLE → LOAD on start; in LOAD, address counter = 0 and count = 0.
- LOAD: in_ready = 1. On a handshake (in_valid & in_ready) with a legal kind, register the address and data and assign the word to the current address.
  - in_last = 1 → DONE.
  - Otherwise, if the current address = 2^ADDR_WIDTH−1 → ERR (overflow); the word is still written.
  - Otherwise stay in LOAD and increment the address.
- LOAD, handshake with illegal kind (6 or 7): nothing is written, count is unchanged → ERR.
- DONE / ERR: in_ready = 0. start → LOAD with address, count and flags cleared.
- start while in LOAD is ignored.
- in_valid without in_ready: no effect; bundle fields are don't-care.

Arithmetic and widths:
- Address counter is ADDR_WIDTH bits and never wraps; overflow is caught before the increment.
- count = number of writes issued, saturating at 2^ADDR_WIDTH.

## Timing

- Handshake in cycle N → imem_we = 1 in cycle N+1, with imem_addr and imem_data registered.
- Throughput: one word per cycle while in_valid is held high.
- imem_we is a single-cycle pulse per accepted legal bundle.
- imem_addr and imem_data hold their last values when imem_we = 0.
- done or error asserts in cycle N+1, coincident with the final write (if any). busy drops in the same cycle.
- count updates in cycle N+1, together with imem_we.
- Reset values: in_ready 0, imem_we 0, imem_addr 0, imem_data 0, busy 0, done 0, error 0, count 0; state IDLE.
- Reset mid-load: a write registered in cycle N does not appear at N+1 if reset is high in cycle N+1. The state returns to IDLE and all outputs take their reset values the cycle after reset is sampled.
- Reset and start high in the same cycle: reset wins.

## Test plan

- R-type: start, then kind=0, rd=3, rs=1, rt=2, shamt=0, aluop=0, in_last=1 → one cycle later imem_we=1, addr=0, data=0x00C22000; done=1, count=1.
- Mixed stream, back-to-back: addi rd=1 rs=0 imm=5, then sw rd=1 rs=0 imm=0x1FFFF, then jal target=0x10 with in_last=1 → three consecutive write cycles with:
  - addr 0: 0x28400005
  - addr 1: 0x3841FFFF
  - addr 2: 0x18000010
  - then done=1, count=3.
- Illegal kind=7 at the second bundle → only addr 0 is written; error=1, count=1, no further imem_we. A later start → busy=1, count=0.
- Overflow with ADDR_WIDTH=2: four bundles, none with in_last → writes at addresses 0–3, then error=1 and in_ready=0, count=4.
- Reset in the cycle after a handshake → no imem_we pulse; all outputs 0 next cycle; state IDLE (in_ready=0 until start).
- Bubbles and stray start: toggle in_valid low for 3 cycles mid-stream and pulse start during LOAD → addresses stay contiguous, start has no effect, no spurious writes.

Source files
------------

// File: rtl/instr_encoder_loader.sv
// ---------------------------------------------------------------------------
// instr_encoder_loader
//
// Packs decoded instruction fields into 32-bit instruction words and writes
// them, in order, into instruction memory starting at word address 0. This
// performs the reverse of the core's opcode decode. It is used to load a
// program while the core is still held in reset.
//
// Instruction word layout (opcode in [31:27]):
//   R-type : {00000, rd, rs, rt, shamt, aluop, 2'b00}
//   addi   : {00101, rd, rs, imm}
//   lw     : {01000, rd, rs, imm}
//   sw     : {00111, rd, rs, imm}   (rd carries the store-data register)
//   setx   : {10101, target}
//   jal    : {00011, target}
//
// Ports:
//   clock      in   1             system clock, rising edge
//   reset      in   1             synchronous, active-high reset
//   start      in   1             pulse that arms a new load (ignored in LOAD)
//   in_valid   in   1             field bundle valid
//   in_ready   out  1             bundle accepted this cycle (high in LOAD)
//   kind       in   3             0 R,1 addi,2 lw,3 sw,4 setx,5 jal,6-7 illegal
//   in_last    in   1             bundle is the last instruction of the program
//   rd,rs,rt   in   5 each        register fields
//   shamt      in   5             shift amount (R-type)
//   aluop      in   5             ALU operation (R-type)
//   imm        in   17            immediate (addi/lw/sw)
//   target     in   27            target (setx/jal)
//   imem_we    out  1             instruction-memory write strobe
//   imem_addr  out  ADDR_WIDTH    write word address
//   imem_data  out  32            encoded instruction word
//   busy       out  1             high in LOAD
//   done       out  1             high in DONE
//   error      out  1             high in ERR (illegal kind or overflow)
//   count      out  ADDR_WIDTH+1  words written in the current load
// ---------------------------------------------------------------------------
module instr_encoder_loader #(
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [2:0]            kind,
    input  logic                  in_last,
    input  logic [4:0]            rd,
    input  logic [4:0]            rs,
    input  logic [4:0]            rt,
    input  logic [4:0]            shamt,
    input  logic [4:0]            aluop,
    input  logic [16:0]           imm,
    input  logic [26:0]           target,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_data,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [ADDR_WIDTH:0]   count
);

    // FSM states
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;
    localparam logic [1:0] ST_ERR  = 2'd3;

    // Instruction kinds presented on the input stream
    localparam logic [2:0] KIND_RTYPE = 3'd0;
    localparam logic [2:0] KIND_ADDI  = 3'd1;
    localparam logic [2:0] KIND_LW    = 3'd2;
    localparam logic [2:0] KIND_SW    = 3'd3;
    localparam logic [2:0] KIND_SETX  = 3'd4;
    localparam logic [2:0] KIND_JAL   = 3'd5;

    // Opcodes placed in bits [31:27]
    localparam logic [4:0] OP_RTYPE = 5'b00000;
    localparam logic [4:0] OP_ADDI  = 5'b00101;
    localparam logic [4:0] OP_LW    = 5'b01000;
    localparam logic [4:0] OP_SW    = 5'b00111;
    localparam logic [4:0] OP_SETX  = 5'b10101;
    localparam logic [4:0] OP_JAL   = 5'b00011;

    localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO  = '0;
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE   = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH-1:0] ADDR_MAX   = '1;
    localparam logic [ADDR_WIDTH:0]   COUNT_ZERO = '0;
    localparam logic [ADDR_WIDTH:0]   COUNT_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH:0]   COUNT_MAX  = {1'b1, {ADDR_WIDTH{1'b0}}};

    // Registers
    logic [1:0]            r_state;
    logic [ADDR_WIDTH-1:0] r_addr;       // next address to be written
    logic [ADDR_WIDTH:0]   r_count;
    logic                  r_we;
    logic [ADDR_WIDTH-1:0] r_imem_addr;
    logic [31:0]           r_imem_data;

    // Combinational signals
    logic        w_in_load;
    logic        w_handshake;
    logic        w_legal;
    logic [31:0] w_word;
    logic        w_at_max;

    assign w_in_load   = (r_state == ST_LOAD);
    assign w_handshake = in_valid & w_in_load;
    assign w_at_max    = (r_addr == ADDR_MAX);

    // Field packing. Kinds 6 and 7 have no encoding and flag the bundle illegal.
    always_comb begin
        // NOTE: every output of a combinational block is assigned a default
        // before the case so that no path leaves it unassigned (no latch).
        w_legal = 1'b1;
        w_word  = '0;
        case (kind)
            KIND_RTYPE: w_word = {OP_RTYPE, rd, rs, rt, shamt, aluop, 2'b00};
            KIND_ADDI:  w_word = {OP_ADDI, rd, rs, imm};
            KIND_LW:    w_word = {OP_LW, rd, rs, imm};
            KIND_SW:    w_word = {OP_SW, rd, rs, imm};
            KIND_SETX:  w_word = {OP_SETX, target};
            KIND_JAL:   w_word = {OP_JAL, target};
            default:    w_legal = 1'b0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            // NOTE: this block has no storage array, so every register is
            // reset; a memory would be left unreset and cleared by writes.
            r_state     <= ST_IDLE;
            r_addr      <= ADDR_ZERO;
            r_count     <= COUNT_ZERO;
            r_we        <= 1'b0;
            r_imem_addr <= ADDR_ZERO;
            r_imem_data <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments only, so
            // every register samples values from before this edge.
            r_we <= 1'b0;
            case (r_state)
                ST_LOAD: begin
                    if (w_handshake) begin
                        if (!w_legal) begin
                            // Illegal kind: nothing written, count unchanged.
                            r_state <= ST_ERR;
                        end else begin
                            r_we        <= 1'b1;
                            r_imem_addr <= r_addr;
                            r_imem_data <= w_word;
                            if (r_count != COUNT_MAX) begin
                                r_count <= r_count + COUNT_ONE;
                            end
                            // The last bundle takes priority over overflow. If
                            // the final word lands on the top address, the load
                            // still completes cleanly.
                            if (in_last) begin
                                r_state <= ST_DONE;
                            end else if (w_at_max) begin
                                // The word has been written, but there is no room
                                // for the next one. Stop here so the address
                                // counter does not wrap.
                                r_state <= ST_ERR;
                            end else begin
                                r_addr <= r_addr + ADDR_ONE;
                            end
                        end
                    end
                end
                ST_IDLE, ST_DONE, ST_ERR: begin
                    if (start) begin
                        r_state <= ST_LOAD;
                        r_addr  <= ADDR_ZERO;
                        r_count <= COUNT_ZERO;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Gate the strobe with reset. A write registered in the cycle before reset
    // then never reaches memory while reset is asserted.
    assign imem_we   = r_we & ~reset;
    assign imem_addr = r_imem_addr;
    assign imem_data = r_imem_data;
    assign in_ready  = w_in_load;
    assign busy      = w_in_load;
    assign done      = (r_state == ST_DONE);
    assign error     = (r_state == ST_ERR);
    assign count     = r_count;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// ---------------------------------------------------------------------------
// Testbench for instr_encoder_loader.
// Inputs are driven 1 time unit after the rising edge. Outputs are sampled
// 1 time unit after the following edge. A second instance, built with
// ADDR_WIDTH=2, shares all inputs and is used for the overflow sequence.
// ---------------------------------------------------------------------------
module tb_instr_encoder_loader;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic        in_valid;
    logic [2:0]  kind;
    logic        in_last;
    logic [4:0]  rd, rs, rt, shamt, aluop;
    logic [16:0] imm;
    logic [26:0] target;

    logic        in_ready, imem_we, busy, done, error;
    logic [11:0] imem_addr;
    logic [31:0] imem_data;
    logic [12:0] count;

    logic        in_ready_s, imem_we_s, busy_s, done_s, error_s;
    logic [1:0]  imem_addr_s;
    logic [31:0] imem_data_s;
    logic [2:0]  count_s;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    instr_encoder_loader #(.ADDR_WIDTH(12)) dut (
        .clock(clock), .reset(reset), .start(start), .in_valid(in_valid),
        .in_ready(in_ready), .kind(kind), .in_last(in_last), .rd(rd), .rs(rs),
        .rt(rt), .shamt(shamt), .aluop(aluop), .imm(imm), .target(target),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_data(imem_data),
        .busy(busy), .done(done), .error(error), .count(count)
    );

    instr_encoder_loader #(.ADDR_WIDTH(2)) dut_s (
        .clock(clock), .reset(reset), .start(start), .in_valid(in_valid),
        .in_ready(in_ready_s), .kind(kind), .in_last(in_last), .rd(rd), .rs(rs),
        .rt(rt), .shamt(shamt), .aluop(aluop), .imm(imm), .target(target),
        .imem_we(imem_we_s), .imem_addr(imem_addr_s), .imem_data(imem_data_s),
        .busy(busy_s), .done(done_s), .error(error_s), .count(count_s)
    );

    typedef struct {
        logic [2:0]  kind;
        logic [4:0]  rd, rs, rt, shamt, aluop;
        logic [16:0] imm;
        logic [26:0] target;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs[8];

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [2:0] k, input logic [4:0] f_rd, input logic [4:0] f_rs,
                         input logic [4:0] f_rt, input logic [4:0] f_shamt,
                         input logic [4:0] f_aluop, input logic [16:0] f_imm,
                         input logic [26:0] f_target, input logic last);
        in_valid = 1'b1;
        kind     = k;
        rd       = f_rd;
        rs       = f_rs;
        rt       = f_rt;
        shamt    = f_shamt;
        aluop    = f_aluop;
        imm      = f_imm;
        target   = f_target;
        in_last  = last;
    endtask

    // Drop valid and put junk on the fields, including an illegal kind.
    task automatic idle_bus;
        in_valid = 1'b0;
        kind     = 3'd7;
        in_last  = 1'b1;
        rd       = 5'h1F;
        imm      = 17'h15555;
        target   = 27'h2AAAAAA;
    endtask

    task automatic arm;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        //               kind  rd     rs     rt     shamt  aluop  imm        target         expected
        vecs[0] = '{3'd0, 5'd3,  5'd1,  5'd2,  5'd0,  5'd0,  17'h0,     27'h0,         32'h00C22000};
        vecs[1] = '{3'd0, 5'd31, 5'd0,  5'd0,  5'd5,  5'd9,  17'h1FFFF, 27'h7FFFFFF,   32'h07C002A4};
        vecs[2] = '{3'd1, 5'd1,  5'd0,  5'd7,  5'd7,  5'd7,  17'h5,     27'h1234567,   32'h28400005};
        vecs[3] = '{3'd2, 5'd2,  5'd3,  5'd0,  5'd0,  5'd0,  17'h10000, 27'h0,         32'h40870000};
        vecs[4] = '{3'd3, 5'd1,  5'd0,  5'd0,  5'd0,  5'd0,  17'h1FFFF, 27'h0,         32'h3841FFFF};
        vecs[5] = '{3'd4, 5'd5,  5'd6,  5'd7,  5'd8,  5'd9,  17'h1FFFF, 27'h7FFFFFF,   32'hAFFFFFFF};
        vecs[6] = '{3'd5, 5'd0,  5'd0,  5'd0,  5'd0,  5'd0,  17'h0,     27'h10,        32'h18000010};
        vecs[7] = '{3'd5, 5'd31, 5'd31, 5'd0,  5'd0,  5'd0,  17'h0,     27'h5555555,   32'h1D555555};

        reset = 1'b1;
        start = 1'b0;
        idle_bus();
        rs = 5'd0; rt = 5'd0; shamt = 5'd0; aluop = 5'd0;
        tick();
        tick();
        reset = 1'b0;
        tick();

        // ---------------- reset values ----------------
        check("rst_in_ready", in_ready, 0);
        check("rst_we", imem_we, 0);
        check("rst_addr", imem_addr, 0);
        check("rst_data", imem_data, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        check("rst_count", count, 0);

        // ---------------- single-instruction encodings ----------------
        for (int i = 0; i < 8; i++) begin
            arm();
            check($sformatf("v%0d_ready", i), in_ready, 1);
            check($sformatf("v%0d_count0", i), count, 0);
            drive(vecs[i].kind, vecs[i].rd, vecs[i].rs, vecs[i].rt, vecs[i].shamt,
                  vecs[i].aluop, vecs[i].imm, vecs[i].target, 1'b1);
            tick();
            check($sformatf("v%0d_we", i), imem_we, 1);
            check($sformatf("v%0d_addr", i), imem_addr, 0);
            check($sformatf("v%0d_data", i), imem_data, vecs[i].exp_data);
            check($sformatf("v%0d_done", i), done, 1);
            check($sformatf("v%0d_busy", i), busy, 0);
            check($sformatf("v%0d_count", i), count, 1);
            idle_bus();
            tick();
            check($sformatf("v%0d_we_off", i), imem_we, 0);
            check($sformatf("v%0d_data_hold", i), imem_data, vecs[i].exp_data);
        end

        // ---------------- mixed back-to-back stream ----------------
        arm();
        drive(3'd1, 5'd1, 5'd0, 5'd0, 5'd0, 5'd0, 17'h5, 27'h0, 1'b0);
        tick();
        check("mix0_we", imem_we, 1);
        check("mix0_addr", imem_addr, 0);
        check("mix0_data", imem_data, 32'h28400005);
        drive(3'd3, 5'd1, 5'd0, 5'd0, 5'd0, 5'd0, 17'h1FFFF, 27'h0, 1'b0);
        tick();
        check("mix1_we", imem_we, 1);
        check("mix1_addr", imem_addr, 1);
        check("mix1_data", imem_data, 32'h3841FFFF);
        check("mix1_busy", busy, 1);
        drive(3'd5, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 17'h0, 27'h10, 1'b1);
        tick();
        check("mix2_we", imem_we, 1);
        check("mix2_addr", imem_addr, 2);
        check("mix2_data", imem_data, 32'h18000010);
        check("mix_done", done, 1);
        check("mix_count", count, 3);
        check("mix_ready", in_ready, 0);
        idle_bus();
        tick();
        check("mix_we_off", imem_we, 0);
        check("mix_addr_hold", imem_addr, 2);

        // ---------------- illegal kind on second bundle ----------------
        arm();
        drive(3'd1, 5'd4, 5'd2, 5'd0, 5'd0, 5'd0, 17'h42, 27'h0, 1'b0);
        tick();
        check("ill0_we", imem_we, 1);
        check("ill0_addr", imem_addr, 0);
        drive(3'd7, 5'd4, 5'd2, 5'd0, 5'd0, 5'd0, 17'h42, 27'h0, 1'b0);
        tick();
        check("ill_we", imem_we, 0);
        check("ill_error", error, 1);
        check("ill_count", count, 1);
        check("ill_busy", busy, 0);
        check("ill_ready", in_ready, 0);
        drive(3'd1, 5'd4, 5'd2, 5'd0, 5'd0, 5'd0, 17'h42, 27'h0, 1'b0);
        tick();
        check("ill_no_more_we", imem_we, 0);
        check("ill_count_hold", count, 1);
        idle_bus();
        arm();
        check("ill_rearm_busy", busy, 1);
        check("ill_rearm_count", count, 0);
        check("ill_rearm_error", error, 0);

        // ---------------- bubbles and stray start in LOAD ----------------
        drive(3'd1, 5'd2, 5'd0, 5'd0, 5'd0, 5'd0, 17'h100, 27'h0, 1'b0);
        tick();
        check("bub0_addr", imem_addr, 0);
        check("bub0_data", imem_data, 32'h28800100);
        idle_bus();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("bub_we_a", imem_we, 0);
        check("bub_busy", busy, 1);
        check("bub_count", count, 1);
        tick();
        check("bub_we_b", imem_we, 0);
        tick();
        check("bub_we_c", imem_we, 0);
        drive(3'd2, 5'd4, 5'd5, 5'd0, 5'd0, 5'd0, 17'h00ABC, 27'h0, 1'b0);
        tick();
        check("bub1_we", imem_we, 1);
        check("bub1_addr", imem_addr, 1);
        check("bub1_data", imem_data, 32'h410A0ABC);
        drive(3'd5, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 17'h0, 27'h3, 1'b1);
        tick();
        check("bub2_addr", imem_addr, 2);
        check("bub2_data", imem_data, 32'h18000003);
        check("bub_done", done, 1);
        check("bub_count3", count, 3);
        idle_bus();

        // ---------------- overflow on the ADDR_WIDTH=2 instance ----------------
        arm();
        check("ovf_ready0", in_ready_s, 1);
        for (int i = 0; i < 4; i++) begin
            drive(3'd1, 5'(i), 5'd0, 5'd0, 5'd0, 5'd0, 17'(i), 27'h0, 1'b0);
            tick();
            check($sformatf("ovf%0d_we", i), imem_we_s, 1);
            check($sformatf("ovf%0d_addr", i), imem_addr_s, i);
            check($sformatf("ovf%0d_data", i), imem_data_s,
                  32'h28000000 | (32'(i) << 22) | 32'(i));
        end
        check("ovf_error", error_s, 1);
        check("ovf_ready", in_ready_s, 0);
        check("ovf_count", count_s, 4);
        check("ovf_wide_busy", busy, 1);
        check("ovf_wide_count", count, 4);
        idle_bus();
        tick();
        check("ovf_we_off", imem_we_s, 0);
        check("ovf_count_hold", count_s, 4);

        // ---------------- reset in the cycle after a handshake ----------------
        drive(3'd1, 5'd1, 5'd0, 5'd0, 5'd0, 5'd0, 17'h7, 27'h0, 1'b0);
        tick();
        idle_bus();
        reset = 1'b1;
        #1;
        check("rml_we_blocked", imem_we, 0);
        tick();
        check("rml_we", imem_we, 0);
        check("rml_addr", imem_addr, 0);
        check("rml_data", imem_data, 0);
        check("rml_busy", busy, 0);
        check("rml_done", done, 0);
        check("rml_error", error, 0);
        check("rml_count", count, 0);
        check("rml_ready", in_ready, 0);
        check("rml_s_error", error_s, 0);
        reset = 1'b0;
        tick();
        check("rml_idle_ready", in_ready, 0);

        // ---------------- reset and start together ----------------
        reset = 1'b1;
        start = 1'b1;
        tick();
        reset = 1'b0;
        start = 1'b0;
        check("rs_busy", busy, 0);
        check("rs_ready", in_ready, 0);
        tick();
        check("rs_still_idle", busy, 0);
        arm();
        check("rs_arm_busy", busy, 1);
        check("rs_arm_ready", in_ready, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
